// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
package program_loader_pkg;

  localparam int INSTRUCTION_LENGTH = 13;
  localparam int INSTRUCTION_MEM    = 1000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    SHIFT,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/program_loader_fifo.sv
// Small circular word buffer (loader_fifo); push and pop may share a cycle.
module loader_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Buffers host instruction words and shifts them LSB-first into a processor's
// serial load register, framing each session with a one-cycle processor reset.
module program_loader #(
  parameter int INSTRUCTION_LENGTH = program_loader_pkg::INSTRUCTION_LENGTH,
  parameter int INSTRUCTION_MEM    = program_loader_pkg::INSTRUCTION_MEM,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] s_data,
  input  logic                          s_last,
  output logic                          proc_reset,
  output logic                          proc_en,
  output logic                          proc_bit,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [9:0]                    words_loaded
);

  import program_loader_pkg::*;

  localparam int ENTRY_W = INSTRUCTION_LENGTH + 1;
  localparam int BIT_W   = $clog2(INSTRUCTION_LENGTH);
  localparam int ACC_W   = $clog2(INSTRUCTION_MEM + 2);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(INSTRUCTION_LENGTH - 1);

  state_t                        state;
  logic [INSTRUCTION_LENGTH-1:0] shift_reg;
  logic                          shift_last;
  logic [BIT_W-1:0]              bit_idx;
  logic                          last_seen;
  logic [ACC_W-1:0]              accepted;

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic session_open;
  logic accept;
  logic overflow;
  logic fill_go;
  logic word_end;
  logic next_pop;
  logic underrun;
  logic go_error;

  loader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({s_last, s_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // IDLE and DONE accept the opening word of a new session regardless of the
  // previous session's last tag.
  always_comb begin
    session_open = (state == IDLE) || (state == DONE);
    s_ready      = 1'b0;
    if (!fifo_full) begin
      if (session_open) begin
        s_ready = 1'b1;
      end else if (((state == FILL) || (state == SHIFT)) && !last_seen) begin
        s_ready = 1'b1;
      end
    end
  end

  assign accept    = s_valid && s_ready;
  assign overflow  = accept && !session_open && (accepted == ACC_W'(INSTRUCTION_MEM));
  assign fill_go   = (state == FILL) &&
                     ((fifo_count >= CNT_W'(2)) || fifo_full || last_seen);
  assign word_end  = (state == SHIFT) && (bit_idx == LAST_BIT);
  assign next_pop  = word_end && !shift_last && !fifo_empty;
  assign underrun  = word_end && !shift_last && fifo_empty;
  assign go_error  = overflow || underrun;
  assign fifo_push = accept && !overflow;
  assign fifo_pop  = fill_go || next_pop;
  assign busy      = (state == CLEAR) || (state == FILL) || (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      proc_reset   <= 1'b0;
      proc_en      <= 1'b0;
      proc_bit     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      shift_reg    <= '0;
      shift_last   <= 1'b0;
      bit_idx      <= '0;
      last_seen    <= 1'b0;
      accepted     <= '0;
    end else begin
      if (accept) begin
        last_seen <= s_last;
        if (session_open) begin
          accepted     <= ACC_W'(1);
          done         <= 1'b0;
          words_loaded <= '0;
        end else begin
          accepted <= accepted + ACC_W'(1);
        end
      end

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= CLEAR;
            proc_reset <= 1'b1;
          end
        end
        CLEAR: begin
          proc_reset <= 1'b0;
          state      <= FILL;
        end
        FILL: begin
          if (fill_go) begin
            state      <= SHIFT;
            proc_en    <= 1'b1;
            proc_bit   <= fifo_head[0];
            shift_reg  <= fifo_head[INSTRUCTION_LENGTH-1:0];
            shift_last <= fifo_head[INSTRUCTION_LENGTH];
            bit_idx    <= '0;
          end
        end
        SHIFT: begin
          if (!word_end) begin
            bit_idx   <= bit_idx + BIT_W'(1);
            shift_reg <= shift_reg >> 1;
            proc_bit  <= shift_reg[1];
          end else begin
            words_loaded <= words_loaded + 10'd1;
            if (shift_last) begin
              state    <= DONE;
              proc_en  <= 1'b0;
              proc_bit <= 1'b0;
              done     <= 1'b1;
            end else if (!fifo_empty) begin
              proc_bit   <= fifo_head[0];
              shift_reg  <= fifo_head[INSTRUCTION_LENGTH-1:0];
              shift_last <= fifo_head[INSTRUCTION_LENGTH];
              bit_idx    <= '0;
            end
          end
        end
        ERROR: begin
          proc_reset <= 1'b1;
          proc_en    <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Underrun and overflow both park the processor in reset until a loader reset.
      if (go_error) begin
        state      <= ERROR;
        proc_en    <= 1'b0;
        proc_bit   <= 1'b0;
        proc_reset <= 1'b1;
        err        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: load sessions, underrun,
// overflow, mid-shift reset and host back-pressure.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [12:0] s_data;
  logic        s_last;
  logic        proc_reset;
  logic        proc_en;
  logic        proc_bit;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic bits_q[$];
  int   run_len;
  int   max_run;
  int   rst_cycles;
  int   max_wl;
  bit   saw_stall;

  always #5 clk = ~clk;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .proc_reset   (proc_reset),
    .proc_en      (proc_en),
    .proc_bit     (proc_bit),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // Record the serial stream and side observations once per cycle.
  always @(negedge clk) begin
    if (proc_en) begin
      bits_q.push_back(proc_bit);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (proc_reset) rst_cycles++;
    if (int'(words_loaded) > max_wl) max_wl = int'(words_loaded);
    if (s_valid && !s_ready && busy) saw_stall = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitor();
    bits_q.delete();
    run_len    = 0;
    max_run    = 0;
    rst_cycles = 0;
    max_wl     = 0;
    saw_stall  = 1'b0;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clearMonitor();
  endtask

  task automatic applyStimulus(input logic [12:0] data, input logic last);
    int cyc = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (!s_ready && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!s_ready) checkOutput("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic waitFlag(input bit want_err, input string tag);
    int cyc = 0;
    while (!(want_err ? err : done) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput(tag, want_err ? err : done, 1);
  endtask

  function automatic logic [127:0] packBits();
    logic [127:0] v = '0;
    for (int i = 0; i < bits_q.size() && i < 128; i++) v[i] = bits_q[i];
    return v;
  endfunction

  initial begin
    logic        exp_bits [13] = '{1,0,1,0,1,1,0,0,0,1,0,1,0};
    logic [12:0] w5 [6] = '{13'h1ABC, 13'h0123, 13'h1F0F, 13'h0555, 13'h1AAA, 13'h0F31};
    int          cyc;

    // Reset state and single-word session
    doReset();
    checkOutput("rst_proc_en", proc_en, 0);
    checkOutput("rst_proc_reset", proc_reset, 0);
    checkOutput("rst_proc_bit", proc_bit, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_words", words_loaded, 0);
    checkOutput("rst_s_ready", s_ready, 1);

    applyStimulus(13'h0A35, 1'b1);
    checkOutput("t1_clear_reset", proc_reset, 1);
    checkOutput("t1_clear_busy", busy, 1);
    waitFlag(1'b0, "t1_done");
    checkOutput("t1_nbits", bits_q.size(), 13);
    for (int i = 0; i < 13; i++) checkOutput($sformatf("t1_bit%0d", i), bits_q[i], exp_bits[i]);
    checkOutput("t1_run", max_run, 13);
    checkOutput("t1_reset_cycles", rst_cycles, 1);
    checkOutput("t1_words", words_loaded, 1);
    checkOutput("t1_en_low", proc_en, 0);
    checkOutput("t1_busy_low", busy, 0);

    // Three words back-to-back, started from DONE
    clearMonitor();
    applyStimulus(13'h1FFF, 1'b0);
    checkOutput("t2_done_cleared", done, 0);
    checkOutput("t2_words_cleared", words_loaded, 0);
    applyStimulus(13'h0000, 1'b0);
    applyStimulus(13'h0001, 1'b1);
    waitFlag(1'b0, "t2_done");
    checkOutput("t2_nbits", bits_q.size(), 39);
    checkOutput("t2_bits", packBits(), {89'd0, 13'h0001, 13'h0000, 13'h1FFF});
    checkOutput("t2_run", max_run, 39);
    checkOutput("t2_words", words_loaded, 3);

    // Underrun: two words without a last tag, host then idle
    doReset();
    applyStimulus(13'h1234, 1'b0);
    applyStimulus(13'h0ACE, 1'b0);
    waitFlag(1'b1, "t3_err");
    checkOutput("t3_en", proc_en, 0);
    checkOutput("t3_proc_reset", proc_reset, 1);
    checkOutput("t3_words", words_loaded, 2);
    checkOutput("t3_bits", packBits(), {102'd0, 13'h0ACE, 13'h1234});
    checkOutput("t3_run", max_run, 26);
    checkOutput("t3_s_ready", s_ready, 0);
    checkOutput("t3_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3_err_sticky", err, 1);

    // Reset during bit 5 of word 1 while a second word waits in the buffer
    doReset();
    applyStimulus(13'h0020, 1'b0);
    applyStimulus(13'h1234, 1'b1);
    cyc = 0;
    while (!proc_en && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("t4_shift_start", proc_en, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_bit5", proc_bit, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t4_en", proc_en, 0);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_s_ready", s_ready, 1);
    checkOutput("t4_words", words_loaded, 0);
    clearMonitor();
    applyStimulus(13'h0A35, 1'b1);
    waitFlag(1'b0, "t4_done");
    checkOutput("t4_nbits", bits_q.size(), 13);
    checkOutput("t4_bits", packBits(), {115'd0, 13'h0A35});
    checkOutput("t4_words_after", words_loaded, 1);

    // Back-pressure with s_valid held high, then a fresh session
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(w5[i], (i == 5));
    waitFlag(1'b0, "t5_done");
    checkOutput("t5_stall_seen", saw_stall, 1);
    checkOutput("t5_nbits", bits_q.size(), 78);
    checkOutput("t5_bits", packBits(), {50'd0, w5[5], w5[4], w5[3], w5[2], w5[1], w5[0]});
    checkOutput("t5_run", max_run, 78);
    checkOutput("t5_words", words_loaded, 6);
    clearMonitor();
    applyStimulus(13'h1555, 1'b1);
    checkOutput("t5_done_cleared", done, 0);
    waitFlag(1'b0, "t5_done2");
    checkOutput("t5_bits2", packBits(), {115'd0, 13'h1555});
    checkOutput("t5_words2", words_loaded, 1);

    // Overflow on the 1001st word of a session
    doReset();
    for (int i = 0; i < 1000; i++) applyStimulus(13'(i), 1'b0);
    checkOutput("t6_no_err_at_1000", err, 0);
    applyStimulus(13'h1001, 1'b0);
    checkOutput("t6_err", err, 1);
    checkOutput("t6_en", proc_en, 0);
    checkOutput("t6_proc_reset", proc_reset, 1);
    checkOutput("t6_s_ready", s_ready, 0);
    checkOutput("t6_wl_bound", (max_wl <= 1000), 1);
    checkOutput("t6_wl_progress", (max_wl >= 990), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INSTRUCTION_LENGTH, default 13, bits per instruction word.
REQ-002 Parameter INSTRUCTION_MEM, default 1000, maximum words per program.
REQ-003 Parameter FIFO_DEPTH, default 4, word buffer entries.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  host word valid.
REQ-007 s_ready  output  1  loader accepts the word; transfer occurs when s_valid&&s_ready at a clock edge.
REQ-008 s_data  input  INSTRUCTION_LENGTH  instruction word; bit 0 is the control bit.
REQ-009 s_last  input  1  marks the final word of a program.
REQ-010 proc_reset  output  1  drives the processor's reset.
REQ-011 proc_en  output  1  drives the processor's load-enable.
REQ-012 proc_bit  output  1  drives the processor's serial load input, inReg[0].
REQ-013 busy  output  1  session in progress (CLEAR, FILL or SHIFT).
REQ-014 done  output  1  last program fully loaded; sticky until the next session starts.
REQ-015 err  output  1  underrun or overflow; sticky until reset.
REQ-016 words_loaded  output  10  count of words fully shifted in the current session.

Function
REQ-017 States SHALL be IDLE, CLEAR, FILL, SHIFT, DONE and ERROR.
REQ-018 The first word accepted in IDLE or DONE SHALL enter the FIFO, clear done and words_loaded, and move to CLEAR.
REQ-019 CLEAR SHALL assert proc_reset for exactly 1 cycle, then move to FILL.
REQ-020 FILL SHALL move to SHIFT once the FIFO holds at least 2 words or holds a word tagged last.
REQ-021 SHIFT SHALL pop one word and present bits 0..12 LSB-first on proc_bit, one per cycle, with proc_en=1; proc_en and proc_bit SHALL be registered outputs.
REQ-022 In SHIFT, proc_en SHALL stay high continuously across word boundaries, with no gap cycles between words.
REQ-023 On bit 12 of a word tagged last, words_loaded SHALL increment and the next cycle SHALL be DONE with proc_en=0 and done=1.
REQ-024 On bit 12 of a word not tagged last:
  - FIFO non-empty: pop the next word; its bit 0 appears in the following cycle.
  - FIFO empty: underrun; go to ERROR.
REQ-025 s_ready SHALL be 1 when the FIFO is not full, the state is IDLE, FILL, SHIFT or DONE, and no s_last word has been accepted in the current session.
REQ-026 A push and a pop SHALL be allowed in the same cycle; fullness is evaluated before the edge.
REQ-027 Accepting a word that would make the session total exceed INSTRUCTION_MEM (the 1001st) SHALL be an overflow; go to ERROR and discard the word.
REQ-028 ERROR SHALL hold proc_en=0, proc_reset=1, s_ready=0 and err=1 until reset.
REQ-029 busy SHALL be 1 in CLEAR, FILL and SHIFT, and 0 otherwise.

Reset
REQ-030 On reset, all of the following SHALL take effect at the next edge and override any in-progress shift:
  - state = IDLE;
  - FIFO emptied;
  - proc_reset=0, proc_en=0, proc_bit=0;
  - busy=0, done=0, err=0;
  - words_loaded=0;
  - s_ready=1 from the first cycle after reset.

Structure
REQ-031 INSTRUCTION_LENGTH, INSTRUCTION_MEM and the state enumeration SHALL live in a shared package, program_loader_pkg.
REQ-032 The word buffer SHALL be a sub-module, loader_fifo, FIFO_DEPTH entries of INSTRUCTION_LENGTH+1 bits (data plus last tag), with synchronous push and pop.

Verification
REQ-033 Single word 13'h0A35 with s_last=1 -> proc_reset high 1 cycle; then proc_en high for exactly 13 cycles with proc_bit = 1,0,1,0,1,1,0,0,0,1,0,1,0; then done=1, words_loaded=1.
REQ-034 Three words 13'h1FFF, 13'h0000, 13'h0001 (last), sent back-to-back -> proc_en high for 39 contiguous cycles, correct bit order, words_loaded=3.
REQ-035 Two words sent without s_last, host then idle -> at the cycle after bit 12 of word 2: err=1, proc_en=0, proc_reset=1, words_loaded=2.
REQ-036 1001 words streamed with no s_last -> err=1 on acceptance of word 1001; words_loaded never exceeds 1000.
REQ-037 reset asserted during bit 5 of word 1 -> next cycle: proc_en=0, busy=0, s_ready=1, FIFO empty; a new session then loads correctly.
REQ-038 s_valid held high while SHIFT drains slowly -> s_ready=0 while the FIFO holds 4 words; no word lost or duplicated; a second session after DONE clears done at its first accepted word.
